// File: rtl/instr_fetch_unit.sv
// Single-issue instruction fetch stage: PC register, req/ready fetch handshake,
// decode-side instruction hold and the beq next-PC path. It also counts accepted fetches.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        stall,
   input  logic        branch,
   input  logic        zero,
   input  logic [15:0] imm16,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_WAIT,
      S_VALID
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] cnt_q, cnt_d;
   logic        valid_q, valid_d;
   logic        req_d;
   logic [31:0] br_off;

   // imm16 is a signed word offset; scale to bytes
   assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      req_d   = 1'b0;
      case (state_q)
         S_FETCH, S_WAIT: begin
            req_d = 1'b1;
            if (imem_ready) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               state_d = S_VALID;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_VALID: begin
            if (!stall) begin
               valid_d = 1'b0;
               cnt_d   = cnt_q + 32'd1;
               pc_d    = pc_plus4 + ((branch && zero) ? br_off : '0);
               state_d = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   // state sits in FETCH during reset, so the request must be masked explicitly
   assign imem_req    = req_d & ~reset;
   assign imem_addr   = pc_q;
   assign pc_out      = pc_q;
   assign pc_plus4    = pc_q + 32'd4;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: two instances (default and wrapping RESET_PC)
// share stimulus and are compared against a transaction-level model of the fetch stage.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        stall = 1'b0;
   logic        branch = 1'b0;
   logic        zero = 1'b0;
   logic [15:0] imm16 = '0;

   logic        req   [2];
   logic [31:0] addr  [2];
   logic [31:0] ins   [2];
   logic        vld   [2];
   logic [31:0] pc    [2];
   logic [31:0] pc4   [2];
   logic [31:0] cnt   [2];

   logic [31:0] rst_pc [2];

   logic        m_have;
   logic [31:0] m_instr;
   logic [31:0] m_cnt;
   logic [31:0] m_pc [2];

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(32'h0040_0000)) u_dut0 (
      .clk(clk), .reset(reset), .imem_req(req[0]), .imem_addr(addr[0]),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(ins[0]),
      .instr_valid(vld[0]), .stall(stall), .branch(branch), .zero(zero),
      .imm16(imm16), .pc_out(pc[0]), .pc_plus4(pc4[0]), .fetch_count(cnt[0])
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (
      .clk(clk), .reset(reset), .imem_req(req[1]), .imem_addr(addr[1]),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(ins[1]),
      .instr_valid(vld[1]), .stall(stall), .branch(branch), .zero(zero),
      .imm16(imm16), .pc_out(pc[1]), .pc_plus4(pc4[1]), .fetch_count(cnt[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic check_model();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("req%0d", k),   32'(req[k]),  32'(!m_have));
         check($sformatf("vld%0d", k),   32'(vld[k]),  32'(m_have));
         check($sformatf("addr%0d", k),  addr[k],      m_pc[k]);
         check($sformatf("pc%0d", k),    pc[k],        m_pc[k]);
         check($sformatf("pc4_%0d", k),  pc4[k],       m_pc[k] + 32'd4);
         check($sformatf("instr%0d", k), ins[k],       m_instr);
         check($sformatf("cnt%0d", k),   cnt[k],       m_cnt);
      end
   endtask

   // one clock: drive, let the edge happen, advance the model, then compare
   task automatic cyc(input logic r, input logic [31:0] d, input logic s,
                      input logic b, input logic z, input logic [15:0] im);
      imem_ready = r;
      imem_rdata = d;
      stall      = s;
      branch     = b;
      zero       = z;
      imm16      = im;
      @(posedge clk);
      if (!m_have) begin
         if (r) begin
            m_have  = 1'b1;
            m_instr = d;
         end
      end else if (!s) begin
         m_have = 1'b0;
         m_cnt  = m_cnt + 32'd1;
         for (int k = 0; k < 2; k++)
            m_pc[k] = m_pc[k] + 32'd4 + ((b && z) ? 32'(int'($signed(im)) * 4) : 32'd0);
      end
      #1;
      check_model();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      m_have  = 1'b0;
      m_instr = '0;
      m_cnt   = '0;
      for (int k = 0; k < 2; k++) m_pc[k] = rst_pc[k];
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_req%0d", k), 32'(req[k]), 32'd0);
         check($sformatf("rst_pc%0d", k),  pc[k],       rst_pc[k]);
         check($sformatf("rst_vld%0d", k), 32'(vld[k]), 32'd0);
         check($sformatf("rst_cnt%0d", k), cnt[k],      32'd0);
         check($sformatf("rst_ins%0d", k), ins[k],      32'd0);
      end
      @(posedge clk);
      #1;
      check("rst_hold_req", 32'(req[0]), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_model();
      check("post_rst_addr", addr[0], 32'h0040_0000);
   endtask

   task automatic fetch_accept(input logic b, input logic z, input logic [15:0] im);
      cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 16'h0);
      cyc(1'b0, 32'h0, 1'b0, b, z, im);
   endtask

   initial begin
      rst_pc[0] = 32'h0040_0000;
      rst_pc[1] = 32'hFFFF_FFFC;
      do_reset();

      // zero-wait fetch then accept
      cyc(1'b1, 32'h8C08_0004, 1'b0, 1'b0, 1'b0, 16'h0);
      check("t2_instr", ins[0], 32'h8C08_0004);
      check("t2_vld",   32'(vld[0]), 32'd1);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      check("t2_pc",    pc[0], 32'h0040_0004);
      check("t2_cnt",   cnt[0], 32'd1);
      check("wrap_pc",  pc[1], 32'h0000_0000);

      // three wait cycles before ready
      for (int i = 0; i < 3; i++) cyc(1'b0, $urandom, 1'b0, 1'b0, 1'b0, 16'h0);
      check("t3_addr", addr[0], 32'h0040_0004);
      cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 16'h0);
      check("t3_instr", ins[0], 32'h1234_5678);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0);

      fetch_accept(1'b0, 1'b0, 16'h0);
      fetch_accept(1'b0, 1'b0, 16'h0);
      check("t4_pre", pc[0], 32'h0040_0010);
      fetch_accept(1'b1, 1'b1, 16'hFFFC);
      check("t4_taken", pc[0], 32'h0040_0004);
      for (int i = 0; i < 3; i++) fetch_accept(1'b0, 1'b0, 16'h0);
      fetch_accept(1'b1, 1'b0, 16'hFFFC);
      check("t4_not_taken", pc[0], 32'h0040_0014);

      // stall with branch conditions toggling must not move anything
      cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 4; i++)
         cyc(1'b1, $urandom, 1'b1, 1'b1, 1'(i % 2), 16'h0010);
      check("t5_hold_instr", ins[0], 32'hDEAD_BEEF);
      check("t5_hold_pc",    pc[0], 32'h0040_0014);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      check("t5_release_pc", pc[0], 32'h0040_0018);

      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 9) < 4),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));

      // abandon a pending request by resetting while waiting
      if (m_have) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      do_reset();
      check("wait_rst_cnt", cnt[0], 32'd0);
      check("wait_rst_pc",  pc[1], 32'hFFFF_FFFC);
      fetch_accept(1'b0, 1'b0, 16'h0);
      check("post_rst_cnt", cnt[1], 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
